// File: rtl/eth_phy_rx_lock_mon.sv
`default_nettype none
// ============================================================================
// Module   : eth_phy_rx_lock_mon
// Purpose  : 64b/66b RX block-lock FSM with bitslip handshake and header BER
//            monitor. Define ETH_PHY_RX_RESET_REQ_EN for the lock-timeout
//            SERDES reset request.
// Revision : 1.0
// ============================================================================
module eth_phy_rx_lock_mon #(
  parameter int DATA_WIDTH          = 64,
  parameter int HDR_WIDTH           = 2,
  parameter int LOCK_COUNT          = 64,
  parameter int INVALID_LIMIT       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531,
  parameter int BER_LIMIT           = 16,
  parameter int RESET_WINDOWS       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_block_lock,
  output logic                 rx_high_ber,
  output logic [6:0]           rx_error_count
);

  localparam int   SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                              BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int   SLIP_W   = $clog2(SLIP_MAX + 1);
  localparam int   CYC_W    = $clog2(COUNT_125US + 1);
  localparam logic WIDTH_OK = (DATA_WIDTH == 32) || (DATA_WIDTH == 64);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        good_q, good_d;
  logic [5:0]        win_q, win_d;
  logic [6:0]        bad_q, bad_d;
  logic [SLIP_W-1:0] slip_q, slip_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [6:0]        ber_q, ber_d;
  logic [6:0]        err_q, err_d;
  logic              high_q, high_d;
  logic              bitslip_q, lock_q, reset_req_q;

  logic w_hdr_valid, w_hdr_good, w_hdr_bad;
  logic w_wrap, w_ber_hit, w_ber_over, w_reset_fire;
  logic [6:0] w_ber_inc;

  // An unsupported datapath width never produces header events, so never locks.
  assign w_hdr_valid = serdes_rx_hdr_valid & WIDTH_OK;
  assign w_hdr_good  = w_hdr_valid &  (serdes_rx_hdr[1] ^ serdes_rx_hdr[0]);
  assign w_hdr_bad   = w_hdr_valid & ~(serdes_rx_hdr[1] ^ serdes_rx_hdr[0]);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    slip_d  = slip_q;
    case (state_q)
      ST_HUNT: begin
        if (w_hdr_bad) begin
          state_d = ST_SLIP;
          good_d  = '0;
          slip_d  = '0;
        end else if (w_hdr_good) begin
          if (good_q == 7'(LOCK_COUNT - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 7'd1;
          end
        end
      end
      ST_SLIP: begin
        if (slip_q == SLIP_W'(BITSLIP_HIGH_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          slip_d  = '0;
        end else begin
          slip_d = slip_q + SLIP_W'(1);
        end
      end
      ST_SETTLE: begin
        if (slip_q == SLIP_W'(BITSLIP_LOW_CYCLES - 1)) begin
          state_d = ST_HUNT;
          slip_d  = '0;
        end else begin
          slip_d = slip_q + SLIP_W'(1);
        end
      end
      ST_LOCKED: begin
        if (w_hdr_bad && (bad_q == 7'(INVALID_LIMIT - 1))) begin
          state_d = ST_SLIP;
          win_d   = '0;
          bad_d   = '0;
          slip_d  = '0;
        end else if (w_hdr_good || w_hdr_bad) begin
          if (win_q == 6'd63) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 6'd1;
            bad_d = bad_q + {6'd0, w_hdr_bad};
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (w_reset_fire) begin
      state_d = ST_HUNT;
      good_d  = '0;
      win_d   = '0;
      bad_d   = '0;
      slip_d  = '0;
    end
  end

  // Headers seen while slipping or settling are misaligned and not counted.
  assign w_ber_hit  = w_hdr_bad && (state_q != ST_SLIP) && (state_q != ST_SETTLE);
  assign w_ber_inc  = (w_ber_hit && (ber_q != 7'd127)) ? ber_q + 7'd1 : ber_q;
  assign w_ber_over = (int'(w_ber_inc) >= BER_LIMIT);
  assign w_wrap     = (cyc_q == CYC_W'(COUNT_125US - 1));

  always_comb begin
    cyc_d  = w_wrap ? '0 : cyc_q + CYC_W'(1);
    ber_d  = w_wrap ? '0 : w_ber_inc;
    err_d  = w_wrap ? w_ber_inc : err_q;
    high_d = w_wrap ? w_ber_over : (high_q | w_ber_over);
  end

`ifdef ETH_PHY_RX_RESET_REQ_EN
  localparam int UNL_W = $clog2(RESET_WINDOWS + 1);

  logic [UNL_W-1:0] unlock_q, unlock_d;
  logic             seen_q, seen_d;
  logic             w_win_unlocked;

  // The wrap cycle's own lock value is the pre-loss state, so OR it in here.
  assign w_win_unlocked = ~(seen_q | lock_q);
  assign w_reset_fire   = w_wrap & w_win_unlocked &
                          (unlock_q == UNL_W'(RESET_WINDOWS - 1));

  always_comb begin
    unlock_d = unlock_q;
    seen_d   = seen_q | lock_q;
    if (w_wrap) begin
      seen_d   = 1'b0;
      unlock_d = (!w_win_unlocked || w_reset_fire) ? '0 : unlock_q + UNL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unlock_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      unlock_q <= unlock_d;
      seen_q   <= seen_d;
    end
  end
`else
  logic [31:0] w_unused_reset_windows;
  assign w_unused_reset_windows = RESET_WINDOWS;
  assign w_reset_fire           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      good_q      <= '0;
      win_q       <= '0;
      bad_q       <= '0;
      slip_q      <= '0;
      cyc_q       <= '0;
      ber_q       <= '0;
      err_q       <= '0;
      high_q      <= 1'b0;
      bitslip_q   <= 1'b0;
      lock_q      <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      win_q       <= win_d;
      bad_q       <= bad_d;
      slip_q      <= slip_d;
      cyc_q       <= cyc_d;
      ber_q       <= ber_d;
      err_q       <= err_d;
      high_q      <= high_d;
      bitslip_q   <= (state_d == ST_SLIP);
      lock_q      <= (state_d == ST_LOCKED);
      reset_req_q <= w_reset_fire;
    end
  end

  assign serdes_rx_bitslip   = bitslip_q;
  assign serdes_rx_reset_req = reset_req_q;
  assign rx_block_lock       = lock_q;
  assign rx_high_ber         = high_q;
  assign rx_error_count      = err_q;

endmodule
`default_nettype wire
